// File: rtl/spi_burst_master.sv
// spi_burst_master: SPI mode-0 byte engine that holds CSn low across a 1..MAX_BYTES_PER_CS byte burst
module spi_burst_master #(
  parameter int CLKS_PER_HALF_BIT = 5,
  parameter int MAX_BYTES_PER_CS = 4,
  parameter int CS_INACTIVE_CLKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_tx_count,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic       o_done,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  output logic [1:0] o_rx_count,
  output logic       o_sck,
  input  logic       i_miso,
  output logic       o_mosi,
  output logic       o_csn
);
  localparam int HW = $clog2(CLKS_PER_HALF_BIT + 1);
  localparam int CW = $clog2(CS_INACTIVE_CLKS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_BYTE, CS_HOLD} state_t;
  state_t state, state_d;
  logic [HW-1:0] half_cnt;
  logic [CW-1:0] hold_cnt;
  logic [3:0] edge_cnt;
  logic [6:0] tx_sr;
  logic [7:0] rx_sr;
  logic [2:0] bytes_left;
  logic [1:0] idx;
  logic can_accept, accept, count_ok, half_end, last_edge, hold_end;
  assign can_accept = state == IDLE || state == WAIT_BYTE;
  assign accept = can_accept && i_tx_dv;
  assign count_ok = i_tx_count != 3'd0 && i_tx_count <= 3'(MAX_BYTES_PER_CS);
  assign half_end = half_cnt == HW'(CLKS_PER_HALF_BIT - 1);
  assign last_edge = half_end && o_sck && edge_cnt == 4'd15;
  assign hold_end = hold_cnt == CW'(CS_INACTIVE_CLKS - 1);
  always_ff @(posedge clk) assert (CLKS_PER_HALF_BIT > 1) else $error("CLKS_PER_HALF_BIT must be >= 2");
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (accept && count_ok) state_d = SHIFT;
      SHIFT:     if (last_edge) state_d = bytes_left > 3'd1 ? WAIT_BYTE : CS_HOLD;
      WAIT_BYTE: if (accept) state_d = SHIFT;
      CS_HOLD:   if (hold_end) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    o_csn = state == IDLE || state == CS_HOLD;
    o_tx_ready = can_accept && !i_tx_dv;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      hold_cnt <= '0;
      edge_cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      bytes_left <= '0;
      idx <= '0;
      o_sck <= 1'b0;
      o_mosi <= 1'b0;
      o_done <= 1'b0;
      o_rx_dv <= 1'b0;
      o_rx_byte <= '0;
      o_rx_count <= '0;
    end else begin
      o_rx_dv <= 1'b0;
      o_done <= 1'b0;
      if (accept && (state == WAIT_BYTE || count_ok)) begin
        tx_sr <= i_tx_byte[6:0];
        o_mosi <= i_tx_byte[7];
        half_cnt <= '0;
        edge_cnt <= '0;
      end
      if (state == IDLE && accept) begin
        bytes_left <= i_tx_count;
        idx <= '0;
        o_done <= !count_ok;
      end
      if (state == SHIFT) begin
        half_cnt <= half_end ? '0 : half_cnt + 1'b1;
        if (half_end) begin
          o_sck <= !o_sck;
          edge_cnt <= edge_cnt + 4'd1;
          if (!o_sck) rx_sr <= {rx_sr[6:0], i_miso};
          else if (last_edge) begin
            o_rx_dv <= 1'b1;
            o_rx_byte <= rx_sr;
            o_rx_count <= idx;
            idx <= idx + 2'd1;
            bytes_left <= bytes_left - 3'd1;
          end else begin
            tx_sr <= {tx_sr[5:0], 1'b0};
            o_mosi <= tx_sr[6];
          end
        end
      end
      hold_cnt <= state == CS_HOLD ? hold_cnt + 1'b1 : '0;
      if (state == CS_HOLD && hold_end) o_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_burst_master.sv
// tb_spi_burst_master: timeline-model bench for the SPI burst engine
`timescale 1ns/1ps
module tb_spi_burst_master;
  localparam int C = 2;
  localparam int BT = 16 * C;
  localparam int CSI = 1;
  localparam int N = 2048;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] i_tx_count = '0;
  logic [7:0] i_tx_byte = '0;
  logic i_tx_dv = 1'b0, miso_inv = 1'b0;
  logic o_tx_ready, o_done, o_rx_dv, o_sck, o_mosi, o_csn, i_miso;
  logic [7:0] o_rx_byte;
  logic [1:0] o_rx_count;
  logic [2:0] a_cnt = '0;
  logic [7:0] a_byte = '0;
  logic a_dv = 1'b0;
  logic a_ready, a_done, a_rxdv, a_sck, a_mosi, a_csn;
  logic [7:0] a_rxb;
  logic [1:0] a_rxc;
  assign i_miso = o_mosi ^ miso_inv;
  spi_burst_master #(.CLKS_PER_HALF_BIT(C), .MAX_BYTES_PER_CS(4), .CS_INACTIVE_CLKS(CSI)) dut (
    .clk(clk), .rst(rst), .i_tx_count(i_tx_count), .i_tx_byte(i_tx_byte), .i_tx_dv(i_tx_dv),
    .o_tx_ready(o_tx_ready), .o_done(o_done), .o_rx_byte(o_rx_byte), .o_rx_dv(o_rx_dv),
    .o_rx_count(o_rx_count), .o_sck(o_sck), .i_miso(i_miso), .o_mosi(o_mosi), .o_csn(o_csn));
  spi_burst_master #(.CLKS_PER_HALF_BIT(C), .MAX_BYTES_PER_CS(4), .CS_INACTIVE_CLKS(4)) dut4 (
    .clk(clk), .rst(rst), .i_tx_count(a_cnt), .i_tx_byte(a_byte), .i_tx_dv(a_dv),
    .o_tx_ready(a_ready), .o_done(a_done), .o_rx_byte(a_rxb), .o_rx_dv(a_rxdv),
    .o_rx_count(a_rxc), .o_sck(a_sck), .i_miso(a_mosi), .o_mosi(a_mosi), .o_csn(a_csn));
  always #5 clk = ~clk;
  typedef struct {
    bit set, csn, sck, acc, done, rxdv, mchk, mosi;
    bit [7:0] rxb;
    bit [1:0] rxc;
  } exp_t;
  exp_t tl [N];
  exp_t ce;
  bit open = 1'b0, open_mosi = 1'b0;
  int cyc = 0, errors = 0, checks = 0;
  int csn_low, csn_fall, n_rise, n_done, n_rxdv, a_done_n, a_rise, a_fall;
  logic [7:0] mosi_log, rxc_log, last_rx, bq [4];
  logic sck_q = 1'b0, csn_q = 1'b1, a_csn_q = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic put(input int t, input exp_t e);
    if (t < N) tl[t] = e;
  endtask
  function automatic exp_t exp_at(input int t);
    exp_t e;
    if (t < N && tl[t].set) return tl[t];
    e = '{default: 0};
    e.csn = !open;
    e.acc = 1'b1;
    e.mchk = open;
    e.mosi = open_mosi;
    return e;
  endfunction
  // expected waveform of one accepted byte, from handshake cycle h through its rx pulse (and done if last)
  task automatic model_accept(input int h, input logic [7:0] b, input bit first, input bit last, input logic [1:0] ix);
    exp_t e;
    e = '{default: 0};
    e.set = 1; e.csn = first; e.acc = 1; e.mchk = !first; e.mosi = open_mosi;
    put(h, e);
    for (int k = 1; k <= BT; k++) begin
      e = '{default: 0};
      e.set = 1; e.mchk = 1;
      e.sck = ((k - 1) / C) % 2 == 1;
      e.mosi = b[7 - (k - 1) / (2 * C)];
      put(h + k, e);
    end
    e = '{default: 0};
    e.set = 1; e.rxdv = 1; e.rxb = b ^ {8{miso_inv}}; e.rxc = ix;
    if (!last) begin
      e.acc = 1; e.mchk = 1; e.mosi = b[0];
      put(h + BT + 1, e);
      open = 1; open_mosi = b[0];
    end else begin
      e.csn = 1;
      put(h + BT + 1, e);
      for (int j = 1; j < CSI; j++) begin
        e = '{default: 0}; e.set = 1; e.csn = 1;
        put(h + BT + 1 + j, e);
      end
      e = '{default: 0}; e.set = 1; e.csn = 1; e.acc = 1; e.done = 1;
      put(h + BT + 1 + CSI, e);
      open = 0;
    end
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask
  task automatic clear_counts();
    csn_low = 0; csn_fall = 0; n_rise = 0; n_done = 0; n_rxdv = 0;
    mosi_log = '0; rxc_log = '0; last_rx = '0;
  endtask
  task automatic send(input int n, input logic [2:0] cnt, input int dvlen);
    int h;
    for (int i = 0; i < n; i++) begin
      h = cyc;
      i_tx_dv = 1'b1;
      i_tx_count = i == 0 ? cnt : 3'd7;
      i_tx_byte = bq[i];
      model_accept(h, bq[i], i == 0, i == n - 1, 2'(i));
      repeat (dvlen) begin @(posedge clk); #1; end
      i_tx_dv = 1'b0;
      wait_until(i < n - 1 ? h + BT + 2 : h + BT + CSI + 3);
    end
  endtask
  task automatic send_invalid(input logic [2:0] cnt, input logic [7:0] b);
    exp_t e;
    int h;
    h = cyc;
    e = '{default: 0}; e.set = 1; e.csn = 1; e.acc = 1;
    put(h, e);
    e.done = 1;
    put(h + 1, e);
    i_tx_dv = 1'b1; i_tx_count = cnt; i_tx_byte = b;
    @(posedge clk); #1;
    i_tx_dv = 1'b0;
    wait_until(h + 4);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      check("rst_csn", o_csn, 1); check("rst_sck", o_sck, 0); check("rst_mosi", o_mosi, 0);
      check("rst_done", o_done, 0); check("rst_rxdv", o_rx_dv, 0);
      check("rst_rxb", o_rx_byte, 0); check("rst_rxc", o_rx_count, 0);
    end else begin
      ce = exp_at(cyc);
      check("csn", o_csn, ce.csn);
      check("sck", o_sck, ce.sck);
      check("ready", o_tx_ready, ce.acc & !i_tx_dv);
      check("done", o_done, ce.done);
      check("rx_dv", o_rx_dv, ce.rxdv);
      if (ce.mchk) check("mosi", o_mosi, ce.mosi);
      if (ce.rxdv) begin
        check("rx_byte", o_rx_byte, ce.rxb);
        check("rx_count", o_rx_count, ce.rxc);
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (!o_csn) csn_low++;
      if (!o_csn && csn_q) csn_fall++;
      if (o_done) n_done++;
      if (o_rx_dv) begin
        n_rxdv++;
        rxc_log = {rxc_log[5:0], o_rx_count};
        last_rx = o_rx_byte;
      end
      if (o_sck && !sck_q) begin
        n_rise++;
        mosi_log = {mosi_log[6:0], o_mosi};
      end
      if (a_done) a_done_n++;
      if (a_csn && !a_csn_q) a_rise = cyc;
      if (!a_csn && a_csn_q) a_fall = cyc;
    end
    sck_q = o_sck;
    csn_q = o_csn;
    a_csn_q = a_csn;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
  initial begin
    int h;
    for (int t = 0; t < N; t++) tl[t] = '{default: 0};
    a_done_n = 0; a_rise = 0; a_fall = 0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_until(cyc + 2);
    check("idle_ready", o_tx_ready, 1);
    // single byte, looped back
    clear_counts();
    bq[0] = 8'hA5;
    send(1, 3'd1, 1);
    check("t1_csn_low", csn_low, 32); check("t1_rises", n_rise, 8);
    check("t1_mosi_seq", mosi_log, 8'hA5); check("t1_rxdv", n_rxdv, 1);
    check("t1_rx", last_rx, 8'hA5); check("t1_done", n_done, 1);
    // four-byte burst with inverted MISO
    clear_counts();
    miso_inv = 1'b1;
    bq[0] = 8'hDE; bq[1] = 8'hAD; bq[2] = 8'hBE; bq[3] = 8'hEF;
    send(4, 3'd4, 1);
    miso_inv = 1'b0;
    check("t2_csn_low", csn_low, 134); check("t2_csn_fall", csn_fall, 1);
    check("t2_rises", n_rise, 32); check("t2_done", n_done, 1);
    check("t2_rxc_seq", rxc_log, 8'h1B); check("t2_rx_last", last_rx, 8'h10);
    // invalid counts
    clear_counts();
    send_invalid(3'd0, 8'h55);
    send_invalid(3'd5, 8'h66);
    check("t3_csn_fall", csn_fall, 0); check("t3_rises", n_rise, 0);
    check("t3_done", n_done, 2); check("t3_rxdv", n_rxdv, 0);
    // dv held three cycles on a two-byte burst
    clear_counts();
    bq[0] = 8'h3C; bq[1] = 8'hC3;
    send(2, 3'd2, 3);
    check("t4_rxdv", n_rxdv, 2); check("t4_rises", n_rise, 16);
    check("t4_done", n_done, 1); check("t4_rx_last", last_rx, 8'hC3);
    // reset in the middle of byte 2 of a 3-byte burst
    bq[0] = 8'h12; bq[1] = 8'h34;
    h = cyc;
    i_tx_dv = 1'b1; i_tx_count = 3'd3; i_tx_byte = bq[0];
    model_accept(h, bq[0], 1, 0, 2'd0);
    @(posedge clk); #1 i_tx_dv = 1'b0;
    wait_until(h + BT + 2);
    h = cyc;
    i_tx_dv = 1'b1; i_tx_byte = bq[1];
    model_accept(h, bq[1], 0, 0, 2'd1);
    @(posedge clk); #1 i_tx_dv = 1'b0;
    wait_until(h + 5 * C);
    rst = 1'b1;
    for (int t = cyc; t < N; t++) tl[t] = '{default: 0};
    open = 0;
    #1;
    check("t5_csn", o_csn, 1); check("t5_sck", o_sck, 0); check("t5_mosi", o_mosi, 0);
    clear_counts();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    wait_until(cyc + 40);
    check("t5_no_done", n_done, 0); check("t5_no_rxdv", n_rxdv, 0);
    bq[0] = 8'h81;
    send(1, 3'd1, 1);
    check("t5_done_after", n_done, 1); check("t5_rx_after", last_rx, 8'h81);
    // CS_INACTIVE_CLKS=4 instance, two back-to-back single-byte bursts
    a_done_n = 0;
    h = cyc;
    a_dv = 1'b1; a_cnt = 3'd1; a_byte = 8'h5A;
    @(posedge clk); #1 a_dv = 1'b0;
    wait_until(h + BT + 5);
    check("t6_done_rise", a_done, 1); check("t6_ready_rise", a_ready, 1);
    wait_until(h + BT + 6);
    a_dv = 1'b1; a_byte = 8'hA5;
    @(posedge clk); #1 a_dv = 1'b0;
    wait_until(h + BT + 8);
    check("t6_cs_gap", a_fall - a_rise, 6);
    wait_until(h + 2 * BT + 12);
    check("t6_done_n", a_done_n, 2); check("t6_rx", a_rxb, 8'hA5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
